// File: rtl/buffer.sv
// Dual-port page buffer: a random-access host port and a sequential flash port
// share one DEPTH x DW store; the flash port walks memory with its own counter.
module buffer #(
    parameter int DW    = 8,
    parameter int AW    = 11,
    parameter int DEPTH = 2**AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          bf_sel,
    input  logic          bf_we,
    input  logic [AW-1:0] bf_addr,
    input  logic [DW-1:0] bf_din,
    output logic [DW-1:0] bf_dout,
    input  logic          fc_clr,
    input  logic          fc_wr_en,
    input  logic          fc_rd_en,
    input  logic [DW-1:0] fc_din,
    output logic [DW-1:0] fc_dout,
    output logic [AW-1:0] fc_addr,
    output logic          fc_last
);

    logic [DW-1:0] mem_q [DEPTH];

    logic [DW-1:0] bf_dout_q, bf_dout_d;
    logic [DW-1:0] fc_dout_q, fc_dout_d;
    logic [AW-1:0] fc_addr_q, fc_addr_d;

    logic host_wr;
    logic host_rd;
    logic fc_step;

    always_comb begin
        host_wr = bf_sel & bf_we;
        host_rd = bf_sel & ~bf_we;
        fc_step = fc_wr_en | fc_rd_en;
    end

    // Reads sample the array before this edge's writes land, so a
    // same-address read-during-write returns the old word.
    always_comb begin
        bf_dout_d = bf_dout_q;
        fc_dout_d = fc_dout_q;
        if (host_rd) begin
            bf_dout_d = mem_q[bf_addr];
        end
        if (fc_rd_en) begin
            fc_dout_d = mem_q[fc_addr_q];
        end
    end

    // Clear beats increment; the counter wraps naturally since DEPTH = 2**AW.
    always_comb begin
        fc_addr_d = fc_addr_q;
        if (fc_clr) begin
            fc_addr_d = '0;
        end else if (fc_step) begin
            fc_addr_d = fc_addr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bf_dout_q <= '0;
            fc_dout_q <= '0;
            fc_addr_q <= '0;
        end else begin
            bf_dout_q <= bf_dout_d;
            fc_dout_q <= fc_dout_d;
            fc_addr_q <= fc_addr_d;
        end
    end

    // Storage is never cleared; writes are suppressed while reset is held.
    // The flash write is issued last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (host_wr) begin
                mem_q[bf_addr] <= bf_din;
            end
            if (fc_wr_en) begin
                mem_q[fc_addr_q] <= fc_din;
            end
        end
    end

    assign bf_dout = bf_dout_q;
    assign fc_dout = fc_dout_q;
    assign fc_addr = fc_addr_q;
    assign fc_last = (fc_addr_q == AW'(DEPTH - 1));

endmodule

// File: tb/tb_buffer.sv
// Self-checking bench for buffer: directed scenarios plus randomized traffic
// checked against a behavioural page-store model.
module tb_buffer;

    localparam int DW    = 8;
    localparam int AW    = 11;
    localparam int DEPTH = 2048;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bf_sel;
    logic          bf_we;
    logic [AW-1:0] bf_addr;
    logic [DW-1:0] bf_din;
    logic [DW-1:0] bf_dout;
    logic          fc_clr;
    logic          fc_wr_en;
    logic          fc_rd_en;
    logic [DW-1:0] fc_din;
    logic [DW-1:0] fc_dout;
    logic [AW-1:0] fc_addr;
    logic          fc_last;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [DW-1:0] m_mem [DEPTH];
    int            m_addr = 0;
    logic [DW-1:0] m_bf = '0;
    logic [DW-1:0] m_fc = '0;

    always #5 clk = ~clk;

    buffer #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bf_sel   (bf_sel),
        .bf_we    (bf_we),
        .bf_addr  (bf_addr),
        .bf_din   (bf_din),
        .bf_dout  (bf_dout),
        .fc_clr   (fc_clr),
        .fc_wr_en (fc_wr_en),
        .fc_rd_en (fc_rd_en),
        .fc_din   (fc_din),
        .fc_dout  (fc_dout),
        .fc_addr  (fc_addr),
        .fc_last  (fc_last)
    );

    task automatic idle();
        bf_sel   = 1'b0;
        bf_we    = 1'b0;
        bf_addr  = '0;
        bf_din   = '0;
        fc_clr   = 1'b0;
        fc_wr_en = 1'b0;
        fc_rd_en = 1'b0;
        fc_din   = '0;
    endtask

    // Apply the page-store rules to the current inputs, then advance one clock.
    task automatic step();
        if (rst_n) begin
            if (bf_sel && !bf_we) m_bf = m_mem[bf_addr];
            if (fc_rd_en)         m_fc = m_mem[m_addr];
            if (bf_sel && bf_we)  m_mem[bf_addr] = bf_din;
            if (fc_wr_en)         m_mem[m_addr] = fc_din;
            if (fc_clr)                     m_addr = 0;
            else if (fc_wr_en || fc_rd_en)  m_addr = (m_addr + 1) % DEPTH;
        end else begin
            m_bf = '0;
            m_fc = '0;
            m_addr = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int a, input int d);
        idle();
        bf_sel = 1'b1; bf_we = 1'b1; bf_addr = AW'(a); bf_din = DW'(d);
        step();
    endtask

    task automatic host_read(input int a);
        idle();
        bf_sel = 1'b1; bf_we = 1'b0; bf_addr = AW'(a);
        step();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) step();
        checks++;
        if (bf_dout !== '0 || fc_dout !== '0 || fc_addr !== '0 || fc_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: bf_dout=%h fc_dout=%h fc_addr=%h fc_last=%b required all 0",
                     bf_dout, fc_dout, fc_addr, fc_last);
        end
        rst_n = 1'b1;
        step();
        $display("test_reset done");
    endtask

    task automatic test_host_rw();
        int addrs [8];
        host_write(12'h010, 8'hA5);
        host_read(12'h010);
        checks++;
        if (bf_dout !== 8'hA5) begin
            failures++;
            $display("FAIL host_read_a5: bf_dout=%h required a5", bf_dout);
        end
        idle();
        step();
        checks++;
        if (bf_dout !== 8'hA5) begin
            failures++;
            $display("FAIL host_dout_hold: bf_dout=%h required a5", bf_dout);
        end
        for (int i = 0; i < 8; i++) begin
            addrs[i] = int'($urandom_range(DEPTH - 1));
            host_write(addrs[i], int'($urandom_range(255)));
        end
        for (int i = 0; i < 8; i++) begin
            host_read(addrs[i]);
            checks++;
            if (bf_dout !== m_bf) begin
                failures++;
                $display("FAIL host_rand_read: addr=%h bf_dout=%h required %h", addrs[i], bf_dout, m_bf);
            end
            $display("host read addr=%h data=%h", addrs[i], bf_dout);
        end
    endtask

    task automatic test_flash_fill();
        idle();
        fc_clr = 1'b1;
        step();
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (fc_addr !== AW'(m_addr) || fc_last !== (m_addr == DEPTH - 1)) begin
                failures++;
                $display("FAIL fill_counter: fc_addr=%h fc_last=%b required %h/%b",
                         fc_addr, fc_last, m_addr, (m_addr == DEPTH - 1));
            end
            idle();
            fc_wr_en = 1'b1;
            fc_din   = DW'(i);
            step();
        end
        checks++;
        if (fc_addr !== '0 || fc_last !== 1'b0) begin
            failures++;
            $display("FAIL fill_wrap: fc_addr=%h fc_last=%b required 0/0", fc_addr, fc_last);
        end
        host_read(12'h7FF);
        checks++;
        if (bf_dout !== 8'hFF) begin
            failures++;
            $display("FAIL fill_read_7ff: bf_dout=%h required ff", bf_dout);
        end
        host_read(12'h123);
        checks++;
        if (bf_dout !== 8'h23) begin
            failures++;
            $display("FAIL fill_read_123: bf_dout=%h required 23", bf_dout);
        end
        $display("test_flash_fill done fc_addr=%h", fc_addr);
    endtask

    task automatic test_flash_read();
        logic [DW-1:0] exp_seq [3];
        exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33;
        for (int i = 0; i < 3; i++) host_write(i, exp_seq[i]);
        idle();
        fc_clr = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            idle();
            fc_rd_en = 1'b1;
            step();
            checks++;
            if (fc_dout !== exp_seq[i]) begin
                failures++;
                $display("FAIL flash_seq_read: idx=%0d fc_dout=%h required %h", i, fc_dout, exp_seq[i]);
            end
            $display("flash read idx=%0d data=%h", i, fc_dout);
        end
        checks++;
        if (fc_addr !== AW'(3)) begin
            failures++;
            $display("FAIL flash_seq_addr: fc_addr=%h required 003", fc_addr);
        end
    endtask

    task automatic test_collision();
        logic [DW-1:0] exp6;
        idle();
        fc_clr = 1'b1;
        step();
        repeat (5) begin
            idle();
            fc_rd_en = 1'b1;
            step();
        end
        idle();
        bf_sel = 1'b1; bf_we = 1'b1; bf_addr = AW'(5); bf_din = 8'h55;
        fc_wr_en = 1'b1; fc_din = 8'hAA;
        step();
        host_read(5);
        checks++;
        if (bf_dout !== 8'hAA) begin
            failures++;
            $display("FAIL collision_flash_wins: bf_dout=%h required aa", bf_dout);
        end
        exp6 = m_mem[6];
        idle();
        fc_clr = 1'b1; fc_rd_en = 1'b1;
        step();
        checks++;
        if (fc_dout !== exp6 || fc_addr !== '0) begin
            failures++;
            $display("FAIL clr_with_read: fc_dout=%h fc_addr=%h required %h/000", fc_dout, fc_addr, exp6);
        end
        $display("test_collision done");
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            idle();
            bf_sel   = 1'($urandom_range(1));
            bf_we    = 1'($urandom_range(1));
            bf_addr  = ($urandom_range(1) != 0) ? AW'(m_addr + int'($urandom_range(2))) : AW'($urandom_range(DEPTH - 1));
            bf_din   = DW'($urandom_range(255));
            fc_wr_en = 1'($urandom_range(1));
            fc_rd_en = 1'($urandom_range(1));
            fc_clr   = ($urandom_range(15) == 0);
            fc_din   = DW'($urandom_range(255));
            step();
            checks++;
            if (bf_dout !== m_bf || fc_dout !== m_fc || fc_addr !== AW'(m_addr) ||
                fc_last !== (m_addr == DEPTH - 1)) begin
                failures++;
                $display("FAIL random_cycle: n=%0d bf=%h fc=%h addr=%h last=%b required %h %h %h %b",
                         n, bf_dout, fc_dout, fc_addr, fc_last, m_bf, m_fc, m_addr, (m_addr == DEPTH - 1));
            end
        end
        $display("test_random done");
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] exp7, exp0;
        host_write(12'h1FF, 8'h5A);
        idle();
        fc_clr = 1'b1;
        step();
        repeat (512) begin
            idle();
            fc_rd_en = 1'b1;
            step();
        end
        host_read(12'h1FF);
        idle();
        checks++;
        if (fc_addr !== AW'(12'h200) || fc_dout !== 8'h5A || bf_dout !== 8'h5A) begin
            failures++;
            $display("FAIL pre_reset_state: fc_addr=%h fc_dout=%h bf_dout=%h required 200/5a/5a",
                     fc_addr, fc_dout, bf_dout);
        end
        exp7 = m_mem[7];
        exp0 = m_mem[0];
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bf_dout !== '0 || fc_dout !== '0 || fc_addr !== '0 || fc_last !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: bf_dout=%h fc_dout=%h fc_addr=%h fc_last=%b required all 0",
                     bf_dout, fc_dout, fc_addr, fc_last);
        end
        // Writes strobed while reset is held must not land.
        bf_sel = 1'b1; bf_we = 1'b1; bf_addr = AW'(7); bf_din = ~exp7;
        fc_wr_en = 1'b1; fc_din = ~exp0;
        step();
        idle();
        rst_n = 1'b1;
        host_read(7);
        checks++;
        if (bf_dout !== exp7) begin
            failures++;
            $display("FAIL no_write_in_reset_host: bf_dout=%h required %h", bf_dout, exp7);
        end
        host_read(0);
        checks++;
        if (bf_dout !== exp0) begin
            failures++;
            $display("FAIL no_write_in_reset_flash: bf_dout=%h required %h", bf_dout, exp0);
        end
        host_read(12'h1FF);
        checks++;
        if (bf_dout !== 8'h5A || fc_addr !== '0) begin
            failures++;
            $display("FAIL mem_kept_after_reset: bf_dout=%h fc_addr=%h required 5a/000", bf_dout, fc_addr);
        end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_host_rw();
        test_flash_fill();
        test_flash_read();
        test_collision();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
